// File: rtl/ram_sync_if.sv
// Request/response bundle for ram_sync: valid/ready request channel and
// registered read-response channel.
interface ram_sync_if #(
  parameter int WORD_SIZE   = 20,
  parameter int WORD_AMOUNT = 30
);
  localparam int ADDR_W = $clog2(WORD_AMOUNT);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_W-1:0]    req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 inj_perr;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_SIZE-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 rsp_perr;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, inj_perr, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_perr
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, inj_perr, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_perr
  );
endinterface

// File: rtl/ram_sync.sv
// ram_sync: single-port synchronous word RAM with hardware clear sweep and a
// registered read response. Define RAM_PARITY_EN to add per-word even parity.
module ram_sync #(
  parameter int WORD_SIZE   = 20,
  parameter int WORD_AMOUNT = 30
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  output logic      busy,
  ram_sync_if.slave bus
);
  localparam int                ADDR_W    = $clog2(WORD_AMOUNT);
  localparam logic [ADDR_W:0]   AMOUNT_X  = (ADDR_W+1)'(WORD_AMOUNT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_AMOUNT - 1);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  function automatic logic parity(input logic [WORD_SIZE-1:0] d);
    return ^d;
  endfunction

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WORD_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_perr_q, rsp_perr_d;

  logic [WORD_SIZE-1:0] mem_q [WORD_AMOUNT];

  logic                 in_range;
  logic                 req_ready;
  logic                 accept;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic [WORD_SIZE-1:0] rd_word;
  logic                 rd_par_bad;

  always_comb begin
    in_range  = ({1'b0, bus.req_addr} < AMOUNT_X);
    req_ready = (state_q == ST_IDLE) && !clear && (!rsp_valid_q || bus.rsp_ready);
    accept    = bus.req_valid && req_ready && !rst;
    rd_word   = in_range ? mem_q[bus.req_addr] : '0;
  end

  // The sweep owns the write port during INIT; otherwise accepted in-range writes.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.req_addr;
    wr_data = bus.req_wdata;
    if (state_q == ST_INIT) begin
      wr_en   = !rst;
      wr_addr = cnt_q;
      wr_data = '0;
    end else if (accept && bus.req_write && in_range) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

`ifdef RAM_PARITY_EN
  logic par_q [WORD_AMOUNT];
  logic wr_par;

  always_comb begin
    wr_par     = (state_q == ST_INIT) ? 1'b0 : (parity(bus.req_wdata) ^ bus.inj_perr);
    rd_par_bad = in_range && (parity(rd_word) != par_q[bus.req_addr]);
  end

  always_ff @(posedge clk) begin
    if (wr_en) par_q[wr_addr] <= wr_par;
  end
`else
  logic unused_inj_perr;
  assign unused_inj_perr = bus.inj_perr;
  assign rd_par_bad      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // A pending response survives a clear; a new read on the consume edge reloads it.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_perr_d  = rsp_perr_q;
    if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;
    if (accept && !bus.req_write) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = rd_word;
      rsp_err_d   = !in_range;
      rsp_perr_d  = rd_par_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_perr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_perr_q  <= rsp_perr_d;
    end
  end

  assign busy          = (state_q == ST_INIT);
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_perr  = rsp_perr_q;
endmodule

// File: tb/tb_ram_sync.sv
// Directed testbench for ram_sync (default parameters 20 x 30); parity
// expectations follow RAM_PARITY_EN.
module tb_ram_sync;
  localparam int WS = 20;
  localparam int WA = 30;
  localparam int AW = $clog2(WA);
`ifdef RAM_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;

  ram_sync_if #(.WORD_SIZE(WS), .WORD_AMOUNT(WA)) bus ();

  ram_sync #(.WORD_SIZE(WS), .WORD_AMOUNT(WA)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WS-1:0] d, input logic inj);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.inj_perr  = inj;
    tick();
    bus.req_valid = 1'b0;
    bus.inj_perr  = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int cycles;
    int bad_busy;
    rst = 1'b1;
    clear = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.inj_perr  = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b1 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b req_ready=%b, expected busy=1 req_ready=0", busy, bus.req_ready);
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0 || bus.rsp_perr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: valid=%b rdata=%h err=%b perr=%b, expected all 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_perr);
    end
    rst = 1'b0;
    cycles = 0;
    bad_busy = 0;
    while (bus.req_ready !== 1'b1 && cycles < 100) begin
      if (busy !== 1'b1) bad_busy++;
      tick();
      cycles++;
    end
    n_checks++;
    if (cycles != 30) begin
      n_fail++;
      $display("FAIL init_len: req_ready rose after %0d cycles, expected 30", cycles);
    end
    n_checks++;
    if (bad_busy != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL init_busy: busy low %0d times during sweep, busy now %b, expected 0 and 0", bad_busy, busy);
    end
    tick();
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL first_read: valid=%b rdata=%h err=%b, expected 1 00000 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL consume: rsp_valid=%b, expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_raw();
    do_write(5, 20'hABCDE, 1'b0);
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_no_rsp: rsp_valid=%b, expected 0", bus.rsp_valid);
    end
    do_read(5);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 20'hABCDE || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL raw: valid=%b rdata=%h err=%b, expected 1 abcde 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    do_read(31);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== '0 || bus.rsp_perr !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_read31: valid=%b err=%b rdata=%h perr=%b, expected 1 1 00000 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.rsp_perr);
    end
    do_write(30, 20'h12345, 1'b0);
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_write_rsp: rsp_valid=%b, expected 0", bus.rsp_valid);
    end
    do_read(29);
    n_checks++;
    if (bus.rsp_err !== 1'b0 || bus.rsp_rdata !== '0) begin
      n_fail++;
      $display("FAIL read29_old: err=%b rdata=%h, expected 0 00000", bus.rsp_err, bus.rsp_rdata);
    end
    do_read(30);
    n_checks++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== '0) begin
      n_fail++;
      $display("FAIL oor_read30: err=%b rdata=%h, expected 1 00000", bus.rsp_err, bus.rsp_rdata);
    end
    do_write(29, 20'h54321, 1'b0);
    do_read(29);
    n_checks++;
    if (bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 20'h54321) begin
      n_fail++;
      $display("FAIL last_word: err=%b rdata=%h, expected 0 54321", bus.rsp_err, bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_write(10, 20'h11111, 1'b0);
    do_write(11, 20'h22222, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 10;
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 20'h11111) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b rdata=%h, expected 1 11111", bus.rsp_valid, bus.rsp_rdata);
    end
    bus.req_addr = 11;
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 20'h22222) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b rdata=%h, expected 1 22222", bus.rsp_valid, bus.rsp_rdata);
    end
    bus.req_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: rsp_valid=%b, expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    do_write(6, 20'h66666, 1'b0);
    bus.rsp_ready = 1'b0;
    do_read(5);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 6;
    bus.req_wdata = 20'h0F0F0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: req_ready=%b, expected 0", i, bus.req_ready);
      end
      tick();
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 20'hABCDE) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b rdata=%h, expected 1 abcde", i, bus.rsp_valid, bus.rsp_rdata);
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_consume: rsp_valid=%b, expected 0", bus.rsp_valid);
    end
    do_read(6);
    n_checks++;
    if (bus.rsp_rdata !== 20'h66666) begin
      n_fail++;
      $display("FAIL bp_no_write: rdata=%h, expected 66666", bus.rsp_rdata);
    end
    do_write(6, 20'h0F0F0, 1'b0);
    do_read(6);
    n_checks++;
    if (bus.rsp_rdata !== 20'h0F0F0) begin
      n_fail++;
      $display("FAIL bp_late_write: rdata=%h, expected 0f0f0", bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_clear();
    int cycles;
    do_write(3, 20'h00001, 1'b0);
    bus.rsp_ready = 1'b0;
    do_read(3);
    clear = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_blocks: req_ready=%b, expected 0", bus.req_ready);
    end
    tick();
    clear = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 20'h00001) begin
      n_fail++;
      $display("FAIL clear_keep_rsp: busy=%b valid=%b rdata=%h, expected 1 1 00001", busy, bus.rsp_valid, bus.rsp_rdata);
    end
    bus.rsp_ready = 1'b1;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      clear = (cycles == 10);
      tick();
      clear = 1'b0;
      cycles++;
    end
    n_checks++;
    if (cycles != 30) begin
      n_fail++;
      $display("FAIL clear_len: busy lasted %0d cycles, expected 30", cycles);
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_consume: rsp_valid=%b, expected 0", bus.rsp_valid);
    end
    do_read(3);
    n_checks++;
    if (bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_data: rdata=%h err=%b, expected 00000 0", bus.rsp_rdata, bus.rsp_err);
    end
    tick();
  endtask

  task automatic test_rst_mid_sweep();
    int cycles;
    do_write(3, 20'h00001, 1'b0);
    bus.rsp_ready = 1'b0;
    do_read(3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: busy=%b valid=%b rdata=%h, expected 1 0 00000", busy, bus.rsp_valid, bus.rsp_rdata);
    end
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (cycles != 30) begin
      n_fail++;
      $display("FAIL rst_sweep_len: busy lasted %0d cycles after rst, expected 30", cycles);
    end
    do_read(3);
    n_checks++;
    if (bus.rsp_rdata !== '0) begin
      n_fail++;
      $display("FAIL rst_sweep_data: rdata=%h, expected 00000", bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_parity();
    do_write(7, 20'h00003, 1'b1);
    do_read(7);
    n_checks++;
    if (bus.rsp_rdata !== 20'h00003 || bus.rsp_perr !== PAR_EN) begin
      n_fail++;
      $display("FAIL par_inj: rdata=%h perr=%b, expected 00003 %b", bus.rsp_rdata, bus.rsp_perr, PAR_EN);
    end
    do_write(8, 20'h00007, 1'b0);
    do_read(8);
    n_checks++;
    if (bus.rsp_rdata !== 20'h00007 || bus.rsp_perr !== 1'b0) begin
      n_fail++;
      $display("FAIL par_clean: rdata=%h perr=%b, expected 00007 0", bus.rsp_rdata, bus.rsp_perr);
    end
    do_write(9, 20'h00001, 1'b1);
    do_read(9);
    n_checks++;
    if (bus.rsp_rdata !== 20'h00001 || bus.rsp_perr !== PAR_EN) begin
      n_fail++;
      $display("FAIL par_inj_odd: rdata=%h perr=%b, expected 00001 %b", bus.rsp_rdata, bus.rsp_perr, PAR_EN);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_out_of_range();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_rst_mid_sweep();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
